// File: rtl/iram_arb_pkg.sv
// -----------------------------------------------------------------------------
// iram_arb_pkg
// Shared defaults and helpers for the IRAM fetch arbiter.
//   DEF_*      : default parameter values for the arbiter and its sub-module
//   MAX_CORES  : largest supported core count; sizes the one-hot helper
//   onehot_to_idx : converts a one-hot vector (up to MAX_CORES bits) to an index
// -----------------------------------------------------------------------------
package iram_arb_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_CNT_W     = 16;

  localparam int MAX_CORES     = 8;
  localparam int MAX_IDX_W     = 3;

  // OR-reduction of set bit positions: exact for one-hot input, 0 for all-zero.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_CORES-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      if (oh[i]) idx |= MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with the rotating priority pointer held inside.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   eligible   : NUM_CORES-wide request vector (already masked by core enable)
//   gnt        : one-hot grant, combinational from eligible and the pointer
//   idx        : binary index of the granted core (0 when no grant)
// The pointer names the highest-priority core; after a grant to core k it
// moves to k+1 (mod NUM_CORES), otherwise it holds.
// -----------------------------------------------------------------------------
module rr_arbiter
  import iram_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] eligible,
  output logic [NUM_CORES-1:0] gnt,
  output logic [IDX_W-1:0]     idx
);

  // One extra bit so ptr + offset never wraps before the modulo correction.
  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_CORES);

  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W:0]       scan;
  logic [IDX_W-1:0]     cand;
  logic                 found;
  logic [MAX_CORES-1:0] gnt_ext;

  // Scan ptr, ptr+1, ... modulo NUM_CORES; the first eligible core wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    gnt   = '0;
    found = 1'b0;
    scan  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      scan = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (scan >= N_EXT) scan = scan - N_EXT;
      cand = scan[IDX_W-1:0];
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_ext                = '0;
    gnt_ext[NUM_CORES-1:0] = gnt;
    idx                    = IDX_W'(onehot_to_idx(gnt_ext));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (idx == IDX_W'(NUM_CORES - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/iram_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// iram_fetch_arbiter
// Shares one single-port, 1-cycle-latency instruction RAM among NUM_CORES
// fetch units, one fetch per cycle, fully pipelined.
//   clk, rst_n  : clock, asynchronous active-low reset
//   core_en     : per-core enable; disabled cores are never granted
//   req         : per-core fetch request
//   req_addr    : flattened request addresses, core k at [k*ADDR_W +: ADDR_W]
//   gnt         : one-hot grant, combinational (address sampled this cycle)
//   rvalid      : one-hot, registered; read data valid for that core
//   rdata       : returned instruction word, broadcast, qualified by rvalid
//   iram_addr   : IRAM address, granted core's address or 0
//   iram_rdata  : IRAM data output (registered inside the IRAM)
//   clr_cnt     : synchronous clear of all fetch counters (beats increment)
//   fetch_cnt   : flattened saturating per-core grant counters
// -----------------------------------------------------------------------------
module iram_fetch_arbiter
  import iram_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_en,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           iram_addr,
  input  logic [DATA_W-1:0]           iram_rdata,
  input  logic                        clr_cnt,
  output logic [NUM_CORES*CNT_W-1:0]  fetch_cnt
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] eligible;
  logic [IDX_W-1:0]     gnt_idx;

  logic                 rsp_v_q, rsp_v_d;
  logic [IDX_W-1:0]     rsp_id_q, rsp_id_d;

  logic [CNT_W-1:0]     cnt_q [NUM_CORES];
  logic [CNT_W-1:0]     cnt_d [NUM_CORES];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign eligible = req & core_en;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .gnt      (gnt),
    .idx      (gnt_idx)
  );

  // ---------------------------------------------------------------------------
  // Address mux: grant is one-hot, so at most one slice is selected.
  // ---------------------------------------------------------------------------
  always_comb begin
    iram_addr = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (gnt[k]) iram_addr = req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Response stage: remembers who was granted so the IRAM word returned one
  // cycle later is tagged for the right core.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_v_d  = |gnt;
    rsp_id_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v_q  <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      rsp_v_q  <= rsp_v_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  always_comb begin
    rvalid = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      rvalid[k] = rsp_v_q && (rsp_id_q == IDX_W'(k));
    end
  end

  // Gated so the broadcast bus is a known value even before the IRAM output
  // has ever been loaded.
  assign rdata = rsp_v_q ? iram_rdata : '0;

  // ---------------------------------------------------------------------------
  // Per-core saturating fetch counters; clear wins over increment.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_cnt)                          cnt_d[k] = '0;
      else if (gnt[k] && (cnt_q[k] != '1))  cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end
  end

  // NOTE: the counter array is a bank of flops, not a RAM, so it is reset
  // explicitly; a true memory array would be left out of the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CORES; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      fetch_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iram_fetch_arbiter
// Self-checking bench: table-driven vectors, hand-written multi-cycle
// sequences (streaming, core disable, reset mid-flight, counter saturation)
// and random traffic, all compared against a behavioural model of the
// arbitration, response and counter rules. Counters are built 4 bits wide so
// saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_iram_fetch_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      core_en, req, gnt, rvalid;
  logic [N*AW-1:0]   req_addr;
  logic [DW-1:0]     rdata;
  logic [DW-1:0]     iram_rdata = '0;
  logic [AW-1:0]     iram_addr;
  logic              clr_cnt;
  logic [N*CW-1:0]   fetch_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iram_fetch_arbiter #(
    .NUM_CORES (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_en    (core_en),
    .req        (req),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .iram_addr  (iram_addr),
    .iram_rdata (iram_rdata),
    .clr_cnt    (clr_cnt),
    .fetch_cnt  (fetch_cnt)
  );

  // IRAM model: synchronous read, one cycle latency, 256 words used.
  logic [DW-1:0] ram [256];
  always @(posedge clk) iram_rdata <= ram[iram_addr[7:0]];

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int            m_ptr;
  bit            m_rv;
  int            m_rid;
  logic [DW-1:0] m_rdata;
  int            m_cnt [N];

  function automatic void m_reset();
    m_ptr   = 0;
    m_rv    = 1'b0;
    m_rid   = 0;
    m_rdata = '0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs (called at posedge+1), compare everything against
  // the model at the falling edge, advance the model, return at next posedge+1.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] en,
                       input logic [N*AW-1:0] a, input logic c,
                       output logic [N-1:0] o_gnt, output logic [AW-1:0] o_addr,
                       output logic [N-1:0] o_rv, output logic [DW-1:0] o_rdata);
    int            w;
    logic [N-1:0]  eg, erv;
    logic [AW-1:0] ea;
    req = r; core_en = en; req_addr = a; clr_cnt = c;
    @(negedge clk);
    w = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (w < 0 && r[k] && en[k]) w = k;
    end
    eg = '0;
    ea = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ea    = a[w*AW +: AW];
    end
    erv = '0;
    if (m_rv) erv[m_rid] = 1'b1;
    o_gnt = gnt; o_addr = iram_addr; o_rv = rvalid; o_rdata = rdata;
    check("gnt", gnt, eg);
    check("iram_addr", iram_addr, ea);
    check("rvalid", rvalid, erv);
    if (m_rv) check("rdata", rdata, m_rdata);
    for (int k = 0; k < N; k++) check("fetch_cnt", fetch_cnt[k*CW +: CW], m_cnt[k]);
    m_rv = (w >= 0);
    if (w >= 0) begin
      m_rid   = w;
      m_rdata = ram[ea[7:0]];
      m_ptr   = (w + 1) % N;
    end
    for (int k = 0; k < N; k++) begin
      if (c)                           m_cnt[k] = 0;
      else if (eg[k] && m_cnt[k] < CNT_MAX) m_cnt[k]++;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  en;
    logic [N-1:0]  gnt;
    logic [AW-1:0] addr;
    logic [N-1:0]  rv;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [10];

  logic [N-1:0]    s_gnt, s_rv;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_rdata;
  logic [N*AW-1:0] fixed_addr;
  logic [N*AW-1:0] a;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = DW'(i * 37 + 11);
    ram[0] = 16'd7;
    ram[1] = 16'd130;
    ram[2] = 16'd15;
    ram[3] = 16'd7;
    fixed_addr = {16'd3, 16'd2, 16'd1, 16'd0};

    //            req      en       gnt      addr   rv       rdata
    tbl[0] = '{4'b0001, 4'b1111, 4'b0001, 16'd0, 4'b0000, 16'd0};
    tbl[1] = '{4'b0000, 4'b1111, 4'b0000, 16'd0, 4'b0001, 16'd7};
    tbl[2] = '{4'b1111, 4'b1111, 4'b0010, 16'd1, 4'b0000, 16'd0};
    tbl[3] = '{4'b1111, 4'b1111, 4'b0100, 16'd2, 4'b0010, 16'd130};
    tbl[4] = '{4'b1111, 4'b1111, 4'b1000, 16'd3, 4'b0100, 16'd15};
    tbl[5] = '{4'b1111, 4'b1111, 4'b0001, 16'd0, 4'b1000, 16'd7};
    tbl[6] = '{4'b0101, 4'b1011, 4'b0001, 16'd0, 4'b0001, 16'd7};
    tbl[7] = '{4'b0100, 4'b1011, 4'b0000, 16'd0, 4'b0001, 16'd7};
    tbl[8] = '{4'b1001, 4'b1111, 4'b1000, 16'd3, 4'b0000, 16'd0};
    tbl[9] = '{4'b0000, 4'b1111, 4'b0000, 16'd0, 4'b1000, 16'd7};

    // Reset state
    rst_n = 1'b0; core_en = '0; req = '0; req_addr = '0; clr_cnt = 1'b0;
    m_reset();
    #12;
    check("reset_rvalid", rvalid, '0);
    check("reset_fetch_cnt", fetch_cnt, '0);
    check("reset_rdata", rdata, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].req, tbl[i].en, fixed_addr, 1'b0, s_gnt, s_addr, s_rv, s_rdata);
      check("tbl_gnt", s_gnt, tbl[i].gnt);
      check("tbl_addr", s_addr, tbl[i].addr);
      check("tbl_rvalid", s_rv, tbl[i].rv);
      if (tbl[i].rv != '0) check("tbl_rdata", s_rdata, tbl[i].rdata);
    end
    check("tbl_counts", fetch_cnt, {4'd2, 4'd1, 4'd1, 4'd3});

    // Core2 streams back-to-back to addresses 0,1,2
    for (int i = 0; i < 3; i++) begin
      a = '0;
      a[2*AW +: AW] = AW'(i);
      cycle(4'b0100, 4'b1111, a, 1'b0, s_gnt, s_addr, s_rv, s_rdata);
      check("stream_gnt", s_gnt, 4'b0100);
    end
    for (int i = 0; i < 2; i++) cycle(4'b0000, 4'b1111, '0, 1'b0, s_gnt, s_addr, s_rv, s_rdata);

    // Core2 disabled while all cores request: fair split among 0,1,3
    cycle(4'b0000, 4'b1111, '0, 1'b1, s_gnt, s_addr, s_rv, s_rdata);
    for (int i = 0; i < 12; i++) cycle(4'b1111, 4'b1011, fixed_addr, 1'b0, s_gnt, s_addr, s_rv, s_rdata);
    check("disable_counts", fetch_cnt, {4'd4, 4'd0, 4'd4, 4'd4});
    cycle(4'b0000, 4'b1111, '0, 1'b0, s_gnt, s_addr, s_rv, s_rdata);

    // Reset the cycle after core1 is granted: its response is dropped
    cycle(4'b0010, 4'b1111, fixed_addr, 1'b0, s_gnt, s_addr, s_rv, s_rdata);
    check("pre_reset_gnt", s_gnt, 4'b0010);
    rst_n = 1'b0; req = '0;
    m_reset();
    @(negedge clk);
    check("midreset_rvalid", rvalid, '0);
    check("midreset_fetch_cnt", fetch_cnt, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req = 4'b1111; core_en = 4'b1111; req_addr = fixed_addr;
    #1;
    check("post_reset_gnt", gnt, 4'b0001);
    check("post_reset_rvalid", rvalid, '0);
    cycle(4'b1111, 4'b1111, fixed_addr, 1'b0, s_gnt, s_addr, s_rv, s_rdata);
    cycle(4'b0000, 4'b1111, '0, 1'b0, s_gnt, s_addr, s_rv, s_rdata);

    // Saturation: 17 grants to core0 after a clear, then clear beats a grant
    cycle(4'b0000, 4'b1111, '0, 1'b1, s_gnt, s_addr, s_rv, s_rdata);
    for (int i = 0; i < 17; i++) cycle(4'b0001, 4'b1111, fixed_addr, 1'b0, s_gnt, s_addr, s_rv, s_rdata);
    check("sat_cnt0", fetch_cnt[CW-1:0], 4'd15);
    cycle(4'b0001, 4'b1111, fixed_addr, 1'b1, s_gnt, s_addr, s_rv, s_rdata);
    check("clr_gnt", s_gnt, 4'b0001);
    check("clr_cnt0", fetch_cnt[CW-1:0], 4'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, en;
      logic         c;
      r  = N'($urandom);
      en = N'($urandom | $urandom);
      c  = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < N; k++) a[k*AW +: AW] = AW'($urandom_range(0, 255));
      cycle(r, en, a, c, s_gnt, s_addr, s_rv, s_rdata);
    end
    cycle(4'b0000, 4'b1111, '0, 1'b0, s_gnt, s_addr, s_rv, s_rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
